// File: rtl/fog_out_framer.sv
// fog_out_framer: frames one latched 32-bit sample as HDR0 HDR1 D3 D2 D1 D0 [CNT] CKS for a byte sink.
// Define FOG_FRAME_CNT_EN to insert an 8-bit frame counter byte (S_CNT) before the checksum.
module fog_out_framer #(
    parameter logic [7:0] HDR0 = 8'hAB,
    parameter logic [7:0] HDR1 = 8'hBA
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_trig,
    input  logic signed [31:0] i_data,
    input  logic               i_tx_ready,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_valid,
    output logic               o_busy,
    output logic [7:0]         o_drop_cnt
);

    typedef enum logic [3:0] {
        IDLE,
        S_HDR0,
        S_HDR1,
        S_D3,
        S_D2,
        S_D1,
        S_D0,
`ifdef FOG_FRAME_CNT_EN
        S_CNT,
`endif
        S_CKS
    } state_t;

    state_t      r_state, w_next;
    logic [31:0] r_data;
    logic [7:0]  r_cks;
    logic [7:0]  r_drop;
    logic [7:0]  w_byte;
    logic        w_xfer, w_acc, w_start, w_drop, w_cks_xfer;
`ifdef FOG_FRAME_CNT_EN
    logic [7:0]  r_fcnt;
`endif

    assign o_tx_valid = (r_state != IDLE);
    assign o_busy     = (r_state != IDLE);
    assign o_tx_data  = w_byte;
    assign o_drop_cnt = r_drop;
    assign w_xfer     = o_tx_valid & i_tx_ready;
    assign w_cks_xfer = (r_state == S_CKS) & w_xfer;
    // A trigger on the checksum transfer chains straight into the next frame instead of dropping
    assign w_start    = i_trig & ((r_state == IDLE) | w_cks_xfer);
    assign w_drop     = i_trig & o_busy & ~w_cks_xfer;

    // Next state, current byte and checksum-accumulate enable
    always_comb begin
        w_next = r_state;
        w_byte = 8'h00;
        w_acc  = 1'b0;
        case (r_state)
            IDLE:   w_next = i_trig ? S_HDR0 : IDLE;
            S_HDR0: begin w_byte = HDR0;          w_next = w_xfer ? S_HDR1 : r_state; end
            S_HDR1: begin w_byte = HDR1;          w_next = w_xfer ? S_D3   : r_state; end
            S_D3:   begin w_byte = r_data[31:24]; w_acc = w_xfer; w_next = w_xfer ? S_D2 : r_state; end
            S_D2:   begin w_byte = r_data[23:16]; w_acc = w_xfer; w_next = w_xfer ? S_D1 : r_state; end
            S_D1:   begin w_byte = r_data[15:8];  w_acc = w_xfer; w_next = w_xfer ? S_D0 : r_state; end
`ifdef FOG_FRAME_CNT_EN
            S_D0:   begin w_byte = r_data[7:0];   w_acc = w_xfer; w_next = w_xfer ? S_CNT : r_state; end
            S_CNT:  begin w_byte = r_fcnt;        w_acc = w_xfer; w_next = w_xfer ? S_CKS : r_state; end
`else
            S_D0:   begin w_byte = r_data[7:0];   w_acc = w_xfer; w_next = w_xfer ? S_CKS : r_state; end
`endif
            S_CKS:  begin w_byte = r_cks;         w_next = w_xfer ? (i_trig ? S_HDR0 : IDLE) : r_state; end
            default: w_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // Sample latch, running checksum and saturating drop counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data <= 32'h0;
            r_cks  <= 8'h00;
            r_drop <= 8'h00;
        end else begin
            if (w_start) begin
                r_data <= i_data;
                r_cks  <= 8'h00;
            end else if (w_acc) begin
                r_cks  <= r_cks + w_byte;
            end
            if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
        end
    end

`ifdef FOG_FRAME_CNT_EN
    // Frame counter advances once per completed frame
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)        r_fcnt <= 8'h00;
        else if (w_cks_xfer) r_fcnt <= r_fcnt + 8'd1;
    end
`endif

endmodule
